// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access stage and its lane aligner:
//   - memory operation encodings carried on i_memop (MEMOP_NONE..MEMOP_SW)
//   - stage FSM state encoding
//   - register-file address / data widths
//   - small helpers that classify an operation
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;

    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LB   = 4'd1;
    localparam logic [3:0] MEMOP_LH   = 4'd2;
    localparam logic [3:0] MEMOP_LW   = 4'd3;
    localparam logic [3:0] MEMOP_LBU  = 4'd4;
    localparam logic [3:0] MEMOP_LHU  = 4'd5;
    localparam logic [3:0] MEMOP_SB   = 4'd6;
    localparam logic [3:0] MEMOP_SH   = 4'd7;
    localparam logic [3:0] MEMOP_SW   = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return op inside {MEMOP_LB, MEMOP_LH, MEMOP_LW, MEMOP_LBU, MEMOP_LHU};
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW};
    endfunction

    // Halfword accesses need an even address, word accesses a word-aligned one.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        logic half_op;
        logic word_op;
        half_op = op inside {MEMOP_LH, MEMOP_LHU, MEMOP_SH};
        word_op = op inside {MEMOP_LW, MEMOP_SW};
        return (half_op && a[0]) || (word_op && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu_align
// Purely combinational byte-lane aligner (the lsu_align unit), shared with
// the future cache.
//   op     in  4   memory operation (mem_stage_pkg MEMOP_*)
//   a      in  2   byte offset within the word
//   sdata  in  32  store data (rs2)
//   rdata  in  32  raw word returned by the bus
//   wmask  out 4   byte-enable mask for stores (0 for anything else)
//   wdata  out 32  lane-replicated store data
//   ldata  out 32  extracted and extended load result
// Low offset bits that do not matter for the access width are ignored, so a
// misaligned halfword/word access is silently truncated.
// ---------------------------------------------------------------------------
module mem_stage_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  a,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: every lane carries a copy of the data so the mask alone
    // decides which bytes the slave updates.
    always_comb begin
        wmask = 4'b0000;
        wdata = sdata;
        case (op)
            MEMOP_SB: begin
                wmask = 4'b0001 << a;
                wdata = {4{sdata[7:0]}};
            end
            MEMOP_SH: begin
                wmask = a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sdata[15:0]}};
            end
            MEMOP_SW: begin
                wmask = 4'b1111;
                wdata = sdata;
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend it.
    always_comb begin
        case (a)
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            2'd3:    ld_byte = rdata[31:24];
            default: ld_byte = rdata[7:0];
        endcase
        ld_half = a[1] ? rdata[31:16] : rdata[15:0];
        ldata   = rdata;
        case (op)
            MEMOP_LB:  ldata = {{24{ld_byte[7]}}, ld_byte};
            MEMOP_LBU: ldata = {24'd0, ld_byte};
            MEMOP_LH:  ldata = {{16{ld_half[15]}}, ld_half};
            MEMOP_LHU: ldata = {16'd0, ld_half};
            default:   ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the RISC-V pipeline with the MEM/WB latch folded in.
// ALU results pass to the register file after one cycle; loads and stores run
// a request/acknowledge bus transaction while stall_req freezes upstream.
//   clk, rst                      clock, asynchronous active-high reset
//   i_wd, i_wreg, i_wdata         writeback request from EX/MEM
//   i_memop, i_maddr, i_sdata     memory operation, address, store data
//   stall_req                     hold upstream stages and the EX/MEM latch
//   bus_req/we/addr/wmask/wdata   registered bus request (word address)
//   bus_rdata, bus_ack            bus response
//   wb_we, wb_waddr, wb_wdata     registered register-file write port
//   misalign_exc                  only with MEM_MISALIGN_TRAP_EN: one-cycle
//                                 pulse for a misaligned access, which is
//                                 then dropped without a bus transaction
// Optional feature macro: MEM_MISALIGN_TRAP_EN (undefined = truncate the
// low address bits and perform the access anyway).
// ---------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wd,
    input  logic [REG_ADDR_W-1:0] i_wreg,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [3:0]            i_memop,
    input  logic [ADDR_W-1:0]     i_maddr,
    input  logic [DATA_W-1:0]     i_sdata,
    output logic                  stall_req,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [3:0]            bus_wmask,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0]     wb_wdata
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_exc
`endif
);

    state_t      state;
    state_t      next_state;
    logic [1:0]  addr_lo;
    logic [1:0]  align_a;
    logic        op_load;
    logic        op_store;
    logic        op_mem;
    logic        misalign;
    logic        start;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    assign op_load  = is_load(i_memop);
    assign op_store = is_store(i_memop);
    assign op_mem   = op_load || op_store;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(i_memop, i_maddr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign start = (state == ST_IDLE) && op_mem && !misalign;

    // bus_addr has its low bits cleared, so the load lane offset is kept
    // separately; stores are prepared from the live address in IDLE.
    assign align_a = (state == ST_BUS) ? addr_lo : i_maddr[1:0];

    mem_stage_lsu_align u_align (
        .op    (i_memop),
        .a     (align_a),
        .sdata (i_sdata),
        .rdata (bus_rdata),
        .wmask (st_mask),
        .wdata (st_data),
        .ldata (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // stall_req is combinational so upstream freezes in the same cycle the
    // operation is seen, and releases in the cycle the acknowledge arrives.
    always_comb begin
        next_state = state;
        stall_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    stall_req  = 1'b1;
                    next_state = ST_BUS;
                end
            end
            ST_BUS: begin
                stall_req = !bus_ack;
                if (bus_ack) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Bus request and writeback registers. A memory op leaves a bubble on the
    // write port until its acknowledge; bus fields other than req/wmask keep
    // their last values after completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wmask <= 4'b0000;
            bus_wdata <= '0;
            addr_lo   <= 2'b00;
            wb_we     <= 1'b0;
            wb_waddr  <= '0;
            wb_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus_req   <= 1'b1;
                        bus_we    <= op_store;
                        bus_addr  <= {i_maddr[ADDR_W-1:2], 2'b00};
                        bus_wmask <= st_mask;
                        bus_wdata <= st_data;
                        addr_lo   <= i_maddr[1:0];
                        wb_we     <= 1'b0;
                    end else if (op_mem) begin
                        wb_we <= 1'b0;
                    end else begin
                        wb_we    <= i_wd;
                        wb_waddr <= i_wreg;
                        wb_wdata <= i_wdata;
                    end
                end
                ST_BUS: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        bus_wmask <= 4'b0000;
                        if (op_load) begin
                            wb_we    <= i_wd;
                            wb_waddr <= i_wreg;
                            wb_wdata <= ld_data;
                        end else begin
                            wb_we <= 1'b0;
                        end
                    end else begin
                        wb_we <= 1'b0;
                    end
                end
                default: wb_we <= 1'b0;
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // One-cycle exception pulse; the offending op is consumed without a bus
    // transaction because start stays low for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= (state == ST_IDLE) && op_mem && misalign;
        end
    end
`endif

endmodule
